// File: rtl/mouse_paddle_pkg.sv
// mouse_paddle_pkg: ps2_mouse field positions and the saturating add shared by both axes.
package mouse_paddle_pkg;
  localparam int STB_BIT   = 24;
  localparam int YSIGN_BIT = 5;
  localparam int XSIGN_BIT = 4;
  localparam int BTN_MSB   = 1;
  localparam int BTN_LSB   = 0;
  localparam int X_MSB     = 15;
  localparam int X_LSB     = 8;
  localparam int Y_MSB     = 23;
  localparam int Y_LSB     = 16;

  // Adds in full int precision, then clamps to the signed out_w-bit range.
  function automatic int sat_add(input int acc, input int d, input int out_w);
    int sum;
    int hi;
    sum = acc + d;
    hi  = (1 << (out_w - 1)) - 1;
    return sum > hi ? hi : (sum < -hi - 1 ? -hi - 1 : sum);
  endfunction
endpackage

// File: rtl/mouse_paddle_mapper_axis_accum.sv
// axis_accum: one paddle axis; scales and clamps a raw 9-bit mouse delta into a saturating accumulator with spring decay.
module axis_accum
  import mouse_paddle_pkg::*;
#(
  parameter int OUT_W      = 8,
  parameter int CLAMP      = 10,
  parameter int SENS_SHIFT = 1
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [8:0]              i_raw,
  input  logic                    i_packet,
  input  logic                    i_clear,
  input  logic                    i_decay_tick,
  output logic signed [OUT_W-1:0] o_acc
);
  logic signed [OUT_W-1:0] r_acc;
  int w_d, w_dc, w_acc, w_next;

  // Priority: clear beats a packet, and a packet drops that cycle's decay step.
  always_comb begin
    w_d    = int'($signed(i_raw)) >>> SENS_SHIFT;
    w_dc   = w_d > CLAMP ? CLAMP : (w_d < -CLAMP ? -CLAMP : w_d);
    w_acc  = int'(r_acc);
    w_next = i_clear ? 0 :
             i_packet ? sat_add(w_acc, w_dc, OUT_W) :
             (i_decay_tick && w_acc != 0) ? (w_acc > 0 ? w_acc - 1 : w_acc + 1) : w_acc;
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) r_acc <= '0;
    else          r_acc <= OUT_W'(w_next);

  assign o_acc = r_acc;
endmodule

// File: rtl/mouse_paddle_mapper.sv
// mouse_paddle_mapper: maps PS/2 mouse packets onto two signed paddle axes and arbitrates
// them against the analog joystick (deadzone reclaim, idle timeout, spring centring).
module mouse_paddle_mapper
  import mouse_paddle_pkg::*;
#(
  parameter int OUT_W       = 8,
  parameter int CLAMP       = 10,
  parameter int SENS_SHIFT  = 1,
  parameter int DEADZONE    = 0,
  parameter int IDLE_CYCLES = 0,
  parameter int DECAY_DIV   = 4096
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [24:0]        ps2_mouse,
  input  logic [2*OUT_W-1:0] joya,
  input  logic [1:0]         joy_btn,
  input  logic               spring,
  output logic [OUT_W-1:0]   axis_x,
  output logic [OUT_W-1:0]   axis_y,
  output logic [1:0]         btn,
  output logic               mouse_active
);
  localparam int IW       = IDLE_CYCLES > 1 ? $clog2(IDLE_CYCLES) : 1;
  localparam int IDLE_MAX = IDLE_CYCLES > 0 ? IDLE_CYCLES - 1 : 0;
  localparam int PW       = DECAY_DIV > 1 ? $clog2(DECAY_DIV) : 1;

  logic          r_primed, r_old_stb, r_active;
  logic [IW-1:0] r_idle;
  logic [PW-1:0] r_pre;
  logic          w_pkt, w_reclaim, w_timeout, w_clear, w_wrap, w_unused;
  logic [OUT_W-1:0] w_acc_x, w_acc_y;
  int            w_jx, w_jy;

  // Magnitudes are taken in int so the most negative joystick value reads as 2^(OUT_W-1).
  always_comb begin
    w_jx      = int'($signed(joya[OUT_W-1:0]));
    w_jy      = int'($signed(joya[2*OUT_W-1:OUT_W]));
    w_pkt     = r_primed && (ps2_mouse[STB_BIT] != r_old_stb);
    w_reclaim = (w_jx < 0 ? -w_jx : w_jx) > DEADZONE || (w_jy < 0 ? -w_jy : w_jy) > DEADZONE;
    w_timeout = IDLE_CYCLES > 0 && r_active && !w_pkt && int'(r_idle) == IDLE_MAX;
    w_clear   = w_reclaim || w_timeout;
    w_wrap    = int'(r_pre) == DECAY_DIV - 1;
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_primed  <= 1'b0;
      r_old_stb <= 1'b0;
      r_active  <= 1'b0;
      r_idle    <= '0;
      r_pre     <= '0;
    end else begin
      r_primed  <= 1'b1;
      r_old_stb <= ps2_mouse[STB_BIT];
      r_active  <= w_clear ? 1'b0 : (w_pkt ? 1'b1 : r_active);
      r_idle    <= (w_pkt || w_clear || !r_active) ? '0 :
                   (int'(r_idle) == IDLE_MAX ? r_idle : r_idle + 1'b1);
      r_pre     <= w_wrap ? '0 : r_pre + 1'b1;
    end

  axis_accum #(.OUT_W(OUT_W), .CLAMP(CLAMP), .SENS_SHIFT(SENS_SHIFT)) u_acc_x (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .i_raw        ({ps2_mouse[XSIGN_BIT], ps2_mouse[X_MSB:X_LSB]}),
    .i_packet     (w_pkt),
    .i_clear      (w_clear),
    .i_decay_tick (spring && w_wrap),
    .o_acc        (w_acc_x)
  );

  axis_accum #(.OUT_W(OUT_W), .CLAMP(CLAMP), .SENS_SHIFT(SENS_SHIFT)) u_acc_y (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .i_raw        ({ps2_mouse[YSIGN_BIT], ps2_mouse[Y_MSB:Y_LSB]}),
    .i_packet     (w_pkt),
    .i_clear      (w_clear),
    .i_decay_tick (spring && w_wrap),
    .o_acc        (w_acc_y)
  );

  assign mouse_active = r_active;
  assign axis_x       = r_active ? w_acc_x : joya[OUT_W-1:0];
  assign axis_y       = r_active ? w_acc_y : joya[2*OUT_W-1:OUT_W];
  assign btn          = r_active ? ps2_mouse[BTN_MSB:BTN_LSB] : joy_btn;
  assign w_unused     = &{1'b0, ps2_mouse[7:6], ps2_mouse[3:2]};
endmodule

// File: tb/tb_mouse_paddle_mapper.sv
// tb_mouse_paddle_mapper: directed plus randomized stimulus against a cycle-level arithmetic reference model.
module tb_mouse_paddle_mapper;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] ps2_mouse = '0;
  logic [15:0] joya = '0;
  logic [1:0]  joy_btn = '0;
  logic        spring = 1'b0;
  logic [7:0]  axis_x, axis_y;
  logic [1:0]  btn;
  logic        mouse_active;

  int n_checks = 0, n_errors = 0;
  int m_ax, m_ay, m_cyc, m_last;
  bit m_primed, m_old, m_act;

  mouse_paddle_mapper #(
    .OUT_W(8), .CLAMP(10), .SENS_SHIFT(1), .DEADZONE(5), .IDLE_CYCLES(100), .DECAY_DIV(4)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_mouse    (ps2_mouse),
    .joya         (joya),
    .joy_btn      (joy_btn),
    .spring       (spring),
    .axis_x       (axis_x),
    .axis_y       (axis_y),
    .btn          (btn),
    .mouse_active (mouse_active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int mag(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic int sgn(input int v);
    return v > 0 ? 1 : (v < 0 ? -1 : 0);
  endfunction

  function automatic int sat(input int v);
    return v > 127 ? 127 : (v < -128 ? -128 : v);
  endfunction

  // Raw {sign,data} as a 9-bit value, halved with floor rounding, then limited to +/-10.
  function automatic int delta(input bit s, input logic [7:0] d);
    int raw, h;
    raw = s ? int'(d) - 256 : int'(d);
    h   = raw < 0 ? (raw - 1) / 2 : raw / 2;
    return h > 10 ? 10 : (h < -10 ? -10 : h);
  endfunction

  task automatic model_reset();
    m_ax = 0; m_ay = 0; m_cyc = 0; m_last = -1000;
    m_primed = 0; m_old = 0; m_act = 0;
  endtask

  // One clock edge of behaviour; m_cyc counts edges since reset so the prescaler phase is m_cyc % 4.
  task automatic model_edge();
    bit pkt, rec, tout;
    pkt  = m_primed && (ps2_mouse[24] != m_old);
    rec  = mag(sx(joya[7:0])) > 5 || mag(sx(joya[15:8])) > 5;
    tout = m_act && !pkt && (m_cyc - m_last) == 100;
    if (rec || tout) begin
      m_ax = 0; m_ay = 0; m_act = 0;
    end else if (pkt) begin
      m_ax = sat(m_ax + delta(ps2_mouse[4], ps2_mouse[15:8]));
      m_ay = sat(m_ay + delta(ps2_mouse[5], ps2_mouse[23:16]));
      m_act = 1; m_last = m_cyc;
    end else if (spring && m_cyc % 4 == 3) begin
      m_ax -= sgn(m_ax); m_ay -= sgn(m_ay);
    end
    m_primed = 1; m_old = ps2_mouse[24]; m_cyc++;
  endtask

  task automatic tick();
    #1;
    chk("act", int'(mouse_active), int'(m_act));
    chk("axis_x", sx(axis_x), m_act ? m_ax : sx(joya[7:0]));
    chk("axis_y", sx(axis_y), m_act ? m_ay : sx(joya[15:8]));
    chk("btn", int'(btn), m_act ? int'(ps2_mouse[1:0]) : int'(joy_btn));
    @(posedge clk_sys);
    if (reset_n) model_edge();
    @(negedge clk_sys);
  endtask

  task automatic pkt(input bit xs, input logic [7:0] xd, input bit ys, input logic [7:0] yd);
    ps2_mouse[24] = ~ps2_mouse[24];
    ps2_mouse[4] = xs; ps2_mouse[15:8] = xd;
    ps2_mouse[5] = ys; ps2_mouse[23:16] = yd;
    tick();
  endtask

  initial begin
    int rate, v;
    model_reset();
    @(negedge clk_sys); @(negedge clk_sys);
    #1;
    chk("rst_act", int'(mouse_active), 0);
    chk("rst_x", sx(axis_x), 0);
    reset_n = 1'b1;
    tick();
    chk("prime_act", int'(mouse_active), 0);

    // Positive saturation
    pkt(0, 8'd40, 0, 8'd0);
    chk("x_first", sx(axis_x), 10);
    chk("x_first_act", int'(mouse_active), 1);
    repeat (13) pkt(0, 8'd40, 0, 8'd0);
    chk("x_sat_hi", sx(axis_x), 127);

    // Reclaim to zero, then negative saturation
    joya[7:0] = 8'd6; tick(); joya = '0; tick();
    repeat (14) pkt(1, 8'h00, 0, 8'd0);
    chk("x_sat_lo", sx(axis_x), -128);

    // Deadzone
    ps2_mouse[1:0] = 2'b01; joy_btn = 2'b10;
    joya[7:0] = 8'd5; tick();
    chk("dz5_act", int'(mouse_active), 1);
    chk("dz5_x", sx(axis_x), -128);
    joya[7:0] = 8'd6; tick();
    chk("dz6_act", int'(mouse_active), 0);
    chk("dz6_x", sx(axis_x), 6);
    chk("dz6_btn", int'(btn), 2);
    joya[7:0] = 8'd0; pkt(0, 8'd4, 0, 8'd0);
    joya[7:0] = 8'd6; pkt(0, 8'd4, 0, 8'd0);
    chk("dz_pkt_act", int'(mouse_active), 0);
    joya = '0;

    // Idle timeout and restart
    pkt(0, 8'd2, 0, 8'd0);
    repeat (99) tick();
    chk("idle99_act", int'(mouse_active), 1);
    tick();
    chk("idle100_act", int'(mouse_active), 0);
    pkt(0, 8'd2, 0, 8'd0);
    repeat (98) tick();
    pkt(0, 8'd2, 0, 8'd0);
    repeat (99) tick();
    chk("restart_act", int'(mouse_active), 1);
    tick();
    chk("restart_to", int'(mouse_active), 0);

    // Spring centring: x = +3, y = -2
    pkt(0, 8'd6, 1, 8'hFC);
    chk("spr_x0", sx(axis_x), 3);
    chk("spr_y0", sx(axis_y), -2);
    spring = 1'b1;
    repeat (12) tick();
    chk("spr_x", sx(axis_x), 0);
    chk("spr_y", sx(axis_y), 0);
    repeat (4) tick();
    chk("spr_hold", sx(axis_x), 0);
    spring = 1'b0;

    // Reset with strobe high, then toggle low
    reset_n = 1'b0; model_reset(); ps2_mouse[24] = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    #1;
    chk("rr_act", int'(mouse_active), 0);
    chk("rr_x", sx(axis_x), 0);
    ps2_mouse[24] = 1'b0;
    tick();
    #1;
    chk("rr_pkt_act", int'(mouse_active), 1);

    // Randomized phase
    rate = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rate = ($urandom_range(0, 2) == 0) ? 1 : 30;
      ps2_mouse[23:0] = 24'($urandom);
      if ($urandom_range(0, 99) < rate) ps2_mouse[24] = ~ps2_mouse[24];
      v = int'($urandom_range(0, 99));
      if (v < 85) joya = '0;
      else if (v < 95) begin
        joya[7:0]  = 8'(int'($urandom_range(0, 10)) - 5);
        joya[15:8] = 8'(int'($urandom_range(0, 10)) - 5);
      end else joya = 16'($urandom);
      joy_btn = 2'($urandom);
      if ($urandom_range(0, 49) == 0) spring = ~spring;
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0; model_reset();
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
